// File: rtl/timer_control_fsm.sv
// Stopwatch run-control: debounced start/stop, lap and clear keys driving a 4-state sequencer.
// Optional lap feature (lap key, LAP state, display_hold) is built only with TIMER_CTRL_LAP_EN.
module timer_control_fsm #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [2:0] key_n,
   output logic       timer_enable,
   output logic       timer_clear,
   output logic       display_hold,
   output logic [1:0] state
);

   localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_RUN    = 2'b01;
   localparam logic [1:0] S_PAUSE  = 2'b10;
   localparam logic [1:0] S_LAP    = 2'b11;

`ifdef TIMER_CTRL_LAP_EN
   localparam logic [2:0] KEY_BUILT = 3'b111;
`else
   localparam logic [2:0] KEY_BUILT = 3'b101;
`endif

   logic [2:0] press;

   for (genvar k = 0; k < 3; k++) begin : g_key
      if (KEY_BUILT[k]) begin : g_on
         logic          sync1;
         logic          sync2;
         logic          level;
         logic          strobe;
         logic [CW-1:0] count;

         // The counter reaching its last value on a mismatching cycle completes
         // DEBOUNCE_CYCLES stable samples, so the level flips on that same edge.
         always_ff @(posedge clock) begin
            if (!resetn) begin
               sync1  <= 1'b1;
               sync2  <= 1'b1;
               level  <= 1'b1;
               count  <= '0;
               strobe <= 1'b0;
            end else begin
               sync1  <= key_n[k];
               sync2  <= sync1;
               strobe <= 1'b0;
               if (sync2 == level) begin
                  count <= '0;
               end else if (count == CNT_LAST) begin
                  level  <= sync2;
                  count  <= '0;
                  strobe <= ~sync2;
               end else begin
                  count <= count + CW'(1);
               end
            end
         end

         assign press[k] = strobe;
      end else begin : g_off
         logic unused_key;
         assign unused_key = key_n[k];
         assign press[k]   = 1'b0;
      end
   end

   logic       ev_start;
   logic       ev_lap;
   logic       ev_clear;
   logic [1:0] next_state;
   logic       do_clear;

   assign ev_start = press[0];
   assign ev_lap   = press[1];
   assign ev_clear = press[2];

   // Priority clear > start > lap among the events valid in the current state.
   always_comb begin
      next_state = state;
      do_clear   = 1'b0;
      case (state)
         S_IDLE: begin
            if (ev_clear) begin
               next_state = S_IDLE;
               do_clear   = 1'b1;
            end else if (ev_start) begin
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            if (ev_start)    next_state = S_PAUSE;
            else if (ev_lap) next_state = S_LAP;
         end
         S_LAP: begin
            if (ev_start)    next_state = S_PAUSE;
            else if (ev_lap) next_state = S_RUN;
         end
         S_PAUSE: begin
            if (ev_clear) begin
               next_state = S_IDLE;
               do_clear   = 1'b1;
            end else if (ev_start) begin
               next_state = S_RUN;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= S_IDLE;
         timer_enable <= 1'b0;
         timer_clear  <= 1'b1;
      end else begin
         state        <= next_state;
         timer_enable <= (next_state == S_RUN) || (next_state == S_LAP);
         timer_clear  <= do_clear;
      end
   end

`ifdef TIMER_CTRL_LAP_EN
   always_ff @(posedge clock) begin
      if (!resetn) display_hold <= 1'b0;
      else         display_hold <= (next_state == S_LAP);
   end
`else
   assign display_hold = 1'b0;
`endif

endmodule

// File: tb/tb_timer_control_fsm.sv
// Scoreboard bench for timer_control_fsm with DEBOUNCE_CYCLES = 4.
// Observed vector is {state, timer_enable, display_hold, timer_clear}.
module tb_timer_control_fsm;

   logic       clock;
   logic       resetn;
   logic [2:0] key_n;
   logic       timer_enable;
   logic       timer_clear;
   logic       display_hold;
   logic [1:0] state;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      string      tag;
      logic [4:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   localparam logic [4:0] O_IDLE   = 5'b00_0_0_0;
   localparam logic [4:0] O_IDLE_C = 5'b00_0_0_1;
   localparam logic [4:0] O_RUN    = 5'b01_1_0_0;
   localparam logic [4:0] O_PAUSE  = 5'b10_0_0_0;
`ifdef TIMER_CTRL_LAP_EN
   localparam logic [4:0] O_LAP    = 5'b11_1_1_0;
`else
   localparam logic [4:0] O_LAP    = 5'b01_1_0_0;
`endif

   timer_control_fsm #(.DEBOUNCE_CYCLES(4)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .key_n        (key_n),
      .timer_enable (timer_enable),
      .timer_clear  (timer_clear),
      .display_hold (display_hold),
      .state        (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [4:0] obs();
      return {state, timer_enable, display_hold, timer_clear};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Stimulus: pull keys low, then 7 edges later (edge 0..6) the response is due.
   task automatic press_keys(input logic [2:0] m);
      key_n = key_n & ~m;
      step(7);
   endtask

   task automatic release_keys(input logic [2:0] m);
      key_n = key_n | m;
      step(8);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      key_n  = 3'b111;
      exp_q.push_back('{"reset_hold", O_IDLE_C});
      step(3);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      resetn = 1'b1;
      exp_q.push_back('{"reset_release", O_IDLE});
      step(1);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
   endtask

   task automatic test_bounce();
      key_n[0] = 1'b0; step(3);
      key_n[0] = 1'b1; step(1);
      key_n[0] = 1'b0; step(2);
      key_n[0] = 1'b1;
      exp_q.push_back('{"bounce_no_event", O_IDLE});
      step(12);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
   endtask

   task automatic test_start_stop();
      key_n[0] = 1'b0;
      exp_q.push_back('{"start_edge5", O_IDLE});
      exp_q.push_back('{"start_edge6", O_RUN});
      exp_q.push_back('{"start_held", O_RUN});
      exp_q.push_back('{"start_release", O_RUN});
      step(6);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      step(1);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      step(3);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b001);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      exp_q.push_back('{"stop", O_PAUSE});
      press_keys(3'b001);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b001);
   endtask

   task automatic test_lap();
      exp_q.push_back('{"lap_resume", O_RUN});
      press_keys(3'b001);
      release_keys(3'b001);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      exp_q.push_back('{"lap_enter", O_LAP});
      press_keys(3'b010);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b010);
      exp_q.push_back('{"lap_exit", O_RUN});
      press_keys(3'b010);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b010);
   endtask

   task automatic test_clear();
      exp_q.push_back('{"clear_in_run", O_RUN});
      press_keys(3'b100);
      release_keys(3'b100);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      exp_q.push_back('{"pause_for_clear", O_PAUSE});
      press_keys(3'b001);
      release_keys(3'b001);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      exp_q.push_back('{"clear_pulse", O_IDLE_C});
      exp_q.push_back('{"clear_pulse_end", O_IDLE});
      press_keys(3'b100);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      step(1);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b100);
   endtask

   task automatic test_priority();
      exp_q.push_back('{"prio_setup", O_PAUSE});
      press_keys(3'b001); release_keys(3'b001);
      press_keys(3'b001); release_keys(3'b001);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      exp_q.push_back('{"prio_clear_wins", O_IDLE_C});
      exp_q.push_back('{"prio_start_dropped", O_IDLE});
      press_keys(3'b101);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b101);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
   endtask

   // Reset partway through a count must restart the full debounce from scratch.
   task automatic test_reset_mid_count();
      key_n[0] = 1'b0;
      step(4);
      resetn = 1'b0;
      exp_q.push_back('{"midreset_clear", O_IDLE_C});
      step(1);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      resetn = 1'b1;
      exp_q.push_back('{"midreset_edge5", O_IDLE});
      exp_q.push_back('{"midreset_edge6", O_RUN});
      step(6);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      step(1);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e.v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", e.tag, obs(), e.v);
      end
      release_keys(3'b001);
   endtask

   initial begin
      resetn = 1'b0;
      key_n  = 3'b111;
      test_reset();
      test_bounce();
      test_start_stop();
      test_lap();
      test_clear();
      test_priority();
      test_reset_mid_count();
      if (exp_q.size() != 0) begin
         n_total++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
